// File: rtl/l1_cache_control_pkg.sv
// Shared types and select-encoding constants for the L1 data cache controller.
package l1_cache_control_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPARE = 2'd1,
      S_WB      = 2'd2,
      S_ALLOC   = 2'd3
   } lc3b_cache_state_t;

   localparam logic DSEL_MERGE   = 1'b0;
   localparam logic DSEL_PMEM    = 1'b1;
   localparam logic PADDR_CPU    = 1'b0;
   localparam logic PADDR_VICTIM = 1'b1;

endpackage

// File: rtl/l1_cache_control_if.sv
// Signal bundle between the cache controller, the CPU/pmem ports and the cache datapath.
// The controller connects through the slave modport; the environment uses master.
interface l1_cache_control_if #(parameter int CNT_W = 16);
   logic             mem_read;
   logic             mem_write;
   logic [1:0]       mem_byte_enable;
   logic             hit0;
   logic             hit1;
   logic             lru;
   logic             victim_valid;
   logic             victim_dirty;
   logic             pmem_resp;
   logic             mem_resp;
   logic             pmem_read;
   logic             pmem_write;
   logic             pmem_addr_sel;
   logic             way_sel;
   logic             data_in_sel;
   logic             load_data;
   logic             load_tag;
   logic             set_valid;
   logic             set_dirty;
   logic             clr_dirty;
   logic             load_lru;
   logic             lru_in;
   logic [CNT_W-1:0] hit_cnt;
   logic [CNT_W-1:0] miss_cnt;
   logic [CNT_W-1:0] wb_cnt;

   modport slave (
      input  mem_read, mem_write, mem_byte_enable, hit0, hit1, lru,
             victim_valid, victim_dirty, pmem_resp,
      output mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel,
             data_in_sel, load_data, load_tag, set_valid, set_dirty,
             clr_dirty, load_lru, lru_in, hit_cnt, miss_cnt, wb_cnt
   );

   modport master (
      output mem_read, mem_write, mem_byte_enable, hit0, hit1, lru,
             victim_valid, victim_dirty, pmem_resp,
      input  mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel,
             data_in_sel, load_data, load_tag, set_valid, set_dirty,
             clr_dirty, load_lru, lru_in, hit_cnt, miss_cnt, wb_cnt
   );
endinterface

// File: rtl/l1_cache_control_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count register with saturation at the maximum value
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + {{(W-1){1'b0}}, 1'b1};
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/l1_cache_control.sv
// Control FSM for the 2-way set-associative L1 data cache: hit check, write merge,
// dirty-victim writeback and line allocation, plus hit/miss/writeback counters.
module l1_cache_control
   import l1_cache_control_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input logic               clk,
   input logic               reset_n,
   l1_cache_control_if.slave bus
);

   lc3b_cache_state_t state_r;
   lc3b_cache_state_t next_state_s;
   logic              recheck_r;
   logic              req_s;
   logic              hit_s;
   logic              hit_inc_s;
   logic              miss_inc_s;
   logic              wb_inc_s;

   assign req_s = bus.mem_read | bus.mem_write;
   assign hit_s = bus.hit0 | bus.hit1;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Marks the compare visit that follows an allocation so it is not counted again
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         recheck_r <= 1'b0;
      end else if (state_r == S_ALLOC) begin
         recheck_r <= 1'b1;
      end else if (state_r == S_COMPARE) begin
         recheck_r <= 1'b0;
      end else begin
         recheck_r <= recheck_r;
      end
   end

   // Next-state and datapath control decode
   always_comb begin
      next_state_s      = state_r;
      bus.mem_resp      = 1'b0;
      bus.pmem_read     = 1'b0;
      bus.pmem_write    = 1'b0;
      bus.pmem_addr_sel = PADDR_CPU;
      bus.way_sel       = 1'b0;
      bus.data_in_sel   = DSEL_MERGE;
      bus.load_data     = 1'b0;
      bus.load_tag      = 1'b0;
      bus.set_valid     = 1'b0;
      bus.set_dirty     = 1'b0;
      bus.clr_dirty     = 1'b0;
      bus.load_lru      = 1'b0;
      bus.lru_in        = 1'b0;
      hit_inc_s         = 1'b0;
      miss_inc_s        = 1'b0;
      wb_inc_s          = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (req_s) begin
               next_state_s = S_COMPARE;
            end else begin
               next_state_s = S_IDLE;
            end
         end
         S_COMPARE: begin
            if (!req_s) begin
               next_state_s = S_IDLE;
            end else if (hit_s) begin
               bus.mem_resp = 1'b1;
               bus.way_sel  = bus.hit1;
               bus.load_lru = 1'b1;
               bus.lru_in   = ~bus.hit1;
               // Write wins when both strobes are up
               if (bus.mem_write) begin
                  bus.load_data   = 1'b1;
                  bus.data_in_sel = DSEL_MERGE;
                  bus.set_dirty   = 1'b1;
               end else begin
                  bus.load_data   = 1'b0;
               end
               hit_inc_s    = ~recheck_r;
               next_state_s = S_IDLE;
            end else begin
               miss_inc_s = ~recheck_r;
               if (bus.victim_valid && bus.victim_dirty) begin
                  next_state_s = S_WB;
               end else begin
                  next_state_s = S_ALLOC;
               end
            end
         end
         S_WB: begin
            bus.pmem_write    = 1'b1;
            bus.pmem_addr_sel = PADDR_VICTIM;
            bus.way_sel       = bus.lru;
            if (bus.pmem_resp) begin
               wb_inc_s     = 1'b1;
               next_state_s = S_ALLOC;
            end else begin
               next_state_s = S_WB;
            end
         end
         S_ALLOC: begin
            bus.pmem_read     = 1'b1;
            bus.pmem_addr_sel = PADDR_CPU;
            bus.way_sel       = bus.lru;
            if (bus.pmem_resp) begin
               bus.load_data   = 1'b1;
               bus.data_in_sel = DSEL_PMEM;
               bus.load_tag    = 1'b1;
               bus.set_valid   = 1'b1;
               bus.clr_dirty   = 1'b1;
               next_state_s    = S_COMPARE;
            end else begin
               next_state_s    = S_ALLOC;
            end
         end
         default: begin
            next_state_s = S_IDLE;
         end
      endcase
   end

   sat_counter #(.W(CNT_W)) u_hit_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (hit_inc_s),
      .count   (bus.hit_cnt)
   );

   sat_counter #(.W(CNT_W)) u_miss_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (miss_inc_s),
      .count   (bus.miss_cnt)
   );

   sat_counter #(.W(CNT_W)) u_wb_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (wb_inc_s),
      .count   (bus.wb_cnt)
   );

endmodule

// File: tb/tb_l1_cache_control.sv
// Scoreboard bench for l1_cache_control: directed requests push expected control
// snapshots; monitors compare them on mem_resp and on pmem transfer completion.
module tb_l1_cache_control;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   int   rd_lat = 1;
   int   wr_lat = 1;
   logic saw_pw = 1'b0;
   logic [11:0] resp_q[$];
   logic [11:0] pmem_q[$];

   l1_cache_control_if #(.CNT_W(CW)) bus ();

   l1_cache_control #(.CNT_W(CW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // {pmem_read, pmem_write, pmem_addr_sel, way_sel, data_in_sel, load_data,
   //  load_tag, set_valid, set_dirty, clr_dirty, load_lru, lru_in}
   function automatic logic [11:0] snap();
      return {bus.pmem_read, bus.pmem_write, bus.pmem_addr_sel, bus.way_sel,
              bus.data_in_sel, bus.load_data, bus.load_tag, bus.set_valid,
              bus.set_dirty, bus.clr_dirty, bus.load_lru, bus.lru_in};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever the DUT completes something
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.mem_resp) begin
            if (resp_q.size() == 0) begin
               chk("unexpected_mem_resp", 32'd1, 32'd0);
            end else begin
               chk("mem_resp_ctrl", {20'd0, snap()}, {20'd0, resp_q.pop_front()});
            end
         end
         if (bus.pmem_resp && (bus.pmem_read || bus.pmem_write)) begin
            if (pmem_q.size() == 0) begin
               chk("unexpected_pmem_done", 32'd1, 32'd0);
            end else begin
               chk("pmem_done_ctrl", {20'd0, snap()}, {20'd0, pmem_q.pop_front()});
            end
         end
         if (bus.pmem_read && bus.pmem_write) begin
            chk("pmem_rd_wr_exclusive", 32'd1, 32'd0);
         end
         if (bus.pmem_write) saw_pw = 1'b1;
      end
   end

   // Physical memory model: pulse pmem_resp after rd_lat/wr_lat strobe cycles
   initial begin
      int cnt;
      cnt = 0;
      bus.pmem_resp = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.pmem_resp = 1'b0;
         if (!reset_n || !(bus.pmem_read || bus.pmem_write)) begin
            cnt = 0;
         end else begin
            cnt++;
            if (cnt >= (bus.pmem_write ? wr_lat : rd_lat)) begin
               bus.pmem_resp = 1'b1;
               cnt = 0;
            end
         end
      end
   end

   task automatic do_req(input logic rd, input logic wr, input logic h0, input logic h1,
                         input logic l, input logic vd, input int exp_lat, input string nm);
      int  n;
      logic got;
      @(posedge clk);
      #1;
      bus.mem_read = rd;  bus.mem_write = wr;
      bus.hit0 = h0;  bus.hit1 = h1;  bus.lru = l;
      bus.victim_valid = 1'b1;  bus.victim_dirty = vd;
      bus.mem_byte_enable = 2'b10;
      n = 0;
      got = 1'b0;
      while (n < 200 && !got) begin
         @(negedge clk);
         n++;
         if (bus.mem_resp) got = 1'b1;
         // Datapath model: the allocated way matches on the re-check
         if (bus.pmem_resp && bus.pmem_read) begin
            if (l) bus.hit1 = 1'b1; else bus.hit0 = 1'b1;
         end
      end
      if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
      else      chk({nm, "_latency"}, n, exp_lat);
      @(posedge clk);
      #1;
      bus.mem_read = 1'b0;  bus.mem_write = 1'b0;
      bus.hit0 = 1'b0;  bus.hit1 = 1'b0;
   endtask

   task automatic chk_cnt(input string nm, input int h, input int m, input int w);
      chk({nm, "_hit_cnt"},  {24'd0, bus.hit_cnt},  h);
      chk({nm, "_miss_cnt"}, {24'd0, bus.miss_cnt}, m);
      chk({nm, "_wb_cnt"},   {24'd0, bus.wb_cnt},   w);
   endtask

   initial begin
      int n;
      bus.mem_read = 1'b0;  bus.mem_write = 1'b0;  bus.mem_byte_enable = 2'b00;
      bus.hit0 = 1'b0;  bus.hit1 = 1'b0;  bus.lru = 1'b0;
      bus.victim_valid = 1'b0;  bus.victim_dirty = 1'b0;

      // Reset state
      #3;
      chk("reset_ctrl", {20'd0, snap()}, 32'd0);
      chk("reset_mem_resp", {31'd0, bus.mem_resp}, 32'd0);
      chk_cnt("reset", 0, 0, 0);
      @(posedge clk);
      #2;
      reset_n = 1'b1;

      // Read hit way1
      resp_q.push_back(12'b000_1_0_0_0_0_0_0_1_0);
      do_req(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, "rd_hit_w1");
      chk_cnt("rd_hit_w1", 1, 0, 0);

      // Write hit way0
      resp_q.push_back(12'b000_0_0_1_0_0_1_0_1_1);
      do_req(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2, "wr_hit_w0");
      chk_cnt("wr_hit_w0", 2, 0, 0);

      // Clean read miss, victim way0, read latency 5
      rd_lat = 5;
      saw_pw = 1'b0;
      pmem_q.push_back(12'b100_0_1_1_1_1_0_1_0_0);
      resp_q.push_back(12'b000_0_0_0_0_0_0_0_1_1);
      do_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, "clean_miss");
      chk("clean_miss_no_pmem_write", {31'd0, saw_pw}, 32'd0);
      chk_cnt("clean_miss", 2, 1, 0);

      // Dirty write miss, victim way1, write latency 3, read latency 2
      wr_lat = 3;
      rd_lat = 2;
      pmem_q.push_back(12'b011_1_0_0_0_0_0_0_0_0);
      pmem_q.push_back(12'b100_1_1_1_1_1_0_1_0_0);
      resp_q.push_back(12'b000_1_0_1_0_0_1_0_1_0);
      do_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8, "dirty_miss");
      chk_cnt("dirty_miss", 2, 2, 1);

      // Request dropped while in compare: no response, no counting
      @(posedge clk);
      #1;
      bus.mem_read = 1'b1;  bus.lru = 1'b0;  bus.victim_dirty = 1'b0;
      @(posedge clk);
      #1;
      bus.mem_read = 1'b0;
      @(negedge clk);
      chk("drop_no_array_write", {20'd0, snap()}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk_cnt("drop", 2, 2, 1);

      // Reset asserted during writeback
      wr_lat = 20;
      @(posedge clk);
      #1;
      bus.mem_write = 1'b1;  bus.lru = 1'b1;  bus.victim_valid = 1'b1;  bus.victim_dirty = 1'b1;
      n = 0;
      while (n < 20 && !bus.pmem_write) begin
         @(negedge clk);
         n++;
      end
      chk("wb_reached", {31'd0, bus.pmem_write}, 32'd1);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("reset_mid_wb_pmem_write", {31'd0, bus.pmem_write}, 32'd0);
      chk("reset_mid_wb_ctrl", {20'd0, snap()}, 32'd0);
      chk_cnt("reset_mid_wb", 0, 0, 0);
      bus.mem_write = 1'b0;
      @(posedge clk);
      #2;
      reset_n = 1'b1;

      // Saturation of hit_cnt at 2^CW-1
      for (int i = 0; i < 255; i++) begin
         resp_q.push_back(12'b000_0_0_0_0_0_0_0_1_1);
         do_req(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, "sat_hit");
      end
      chk_cnt("sat_full", 255, 0, 0);
      // Read and write together behave as a write
      resp_q.push_back(12'b000_0_0_1_0_0_1_0_1_1);
      do_req(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2, "rdwr_hit");
      chk_cnt("sat_hold", 255, 0, 0);

      repeat (2) @(posedge clk);
      chk("resp_q_drained", resp_q.size(), 32'd0);
      chk("pmem_q_drained", pmem_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
